// File: rtl/axi_read_arbiter_2x1.sv
// Round-robin arbiter sharing one AXI4 read port (AR/R) between two masters.
// One burst in flight; grant held from AR issue until the RLAST beat completes.
package params_pkg;
    localparam int AXI_ID_WIDTH   = 4;
    localparam int AXI_ADDR_WIDTH = 32;
    localparam int AXI_DATA_WIDTH = 32;
    localparam int AXI_LEN_WIDTH  = 8;
endpackage

module axi_read_arbiter_2x1
    import params_pkg::*;
#(
    parameter int ID_WIDTH   = AXI_ID_WIDTH,
    parameter int ADDR_WIDTH = AXI_ADDR_WIDTH,
    parameter int DATA_WIDTH = AXI_DATA_WIDTH,
    parameter int LEN_WIDTH  = AXI_LEN_WIDTH
) (
    input  logic                    ACLK,
    input  logic                    ARESETn,
    input  logic [1:0]              s_arvalid,
    output logic [1:0]              s_arready,
    input  logic [2*ID_WIDTH-1:0]   s_arid,
    input  logic [2*ADDR_WIDTH-1:0] s_araddr,
    input  logic [2*LEN_WIDTH-1:0]  s_arlen,
    input  logic [5:0]              s_arsize,
    input  logic [3:0]              s_arburst,
    output logic [1:0]              s_rvalid,
    input  logic [1:0]              s_rready,
    output logic [ID_WIDTH-1:0]     s_rid,
    output logic [DATA_WIDTH-1:0]   s_rdata,
    output logic [1:0]              s_rresp,
    output logic                    s_rlast,
    output logic                    m_arvalid,
    input  logic                    m_arready,
    output logic [ID_WIDTH-1:0]     m_arid,
    output logic [ADDR_WIDTH-1:0]   m_araddr,
    output logic [LEN_WIDTH-1:0]    m_arlen,
    output logic [2:0]              m_arsize,
    output logic [1:0]              m_arburst,
    input  logic                    m_rvalid,
    output logic                    m_rready,
    input  logic [ID_WIDTH-1:0]     m_rid,
    input  logic [DATA_WIDTH-1:0]   m_rdata,
    input  logic [1:0]              m_rresp,
    input  logic                    m_rlast,
    output logic                    len_err
);
    typedef enum logic [1:0] {S_IDLE, S_ADDR, S_DATA} state_t;

    state_t               r_state;
    logic                 r_grant;
    logic                 r_prio;
    logic                 r_len_err;
    logic [LEN_WIDTH:0]   r_beat_cnt;
    logic [LEN_WIDTH-1:0] r_len_q;

    logic w_pick;
    logic w_ar_hs;
    logic w_r_hs;

    assign w_pick  = s_arvalid[r_prio] ? r_prio : ~r_prio;
    assign w_ar_hs = m_arvalid & m_arready;
    assign w_r_hs  = m_rvalid & m_rready;
    assign len_err = r_len_err;

    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            r_state    <= S_IDLE;
            r_grant    <= 1'b0;
            r_prio     <= 1'b0;
            r_len_err  <= 1'b0;
            r_beat_cnt <= '0;
            r_len_q    <= '0;
        end else begin
            unique case (r_state)
                S_IDLE: begin
                    if (|s_arvalid) begin
                        r_grant <= w_pick;
                        r_state <= S_ADDR;
                    end
                end
                S_ADDR: begin
                    if (w_ar_hs) begin
                        r_len_q    <= m_arlen;
                        r_beat_cnt <= '0;
                        r_state    <= S_DATA;
                    end
                end
                S_DATA: begin
                    if (w_r_hs) begin
                        r_beat_cnt <= r_beat_cnt + 1'b1;
                        // RLAST ends the burst even when the count disagrees
                        if (m_rlast) begin
                            if (r_beat_cnt != {1'b0, r_len_q})
                                r_len_err <= 1'b1;
                            r_prio  <= ~r_grant;
                            r_state <= S_IDLE;
                        end
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    always_comb begin
        s_arready = '0;
        m_arvalid = 1'b0;
        m_arid    = '0;
        m_araddr  = '0;
        m_arlen   = '0;
        m_arsize  = '0;
        m_arburst = '0;
        s_rvalid  = '0;
        m_rready  = 1'b0;
        s_rid     = '0;
        s_rdata   = '0;
        s_rresp   = '0;
        s_rlast   = 1'b0;
        unique case (r_state)
            S_ADDR: begin
                m_arvalid          = s_arvalid[r_grant];
                s_arready[r_grant] = m_arready;
                m_arid    = r_grant ? s_arid[2*ID_WIDTH-1:ID_WIDTH]
                                    : s_arid[ID_WIDTH-1:0];
                m_araddr  = r_grant ? s_araddr[2*ADDR_WIDTH-1:ADDR_WIDTH]
                                    : s_araddr[ADDR_WIDTH-1:0];
                m_arlen   = r_grant ? s_arlen[2*LEN_WIDTH-1:LEN_WIDTH]
                                    : s_arlen[LEN_WIDTH-1:0];
                m_arsize  = r_grant ? s_arsize[5:3] : s_arsize[2:0];
                m_arburst = r_grant ? s_arburst[3:2] : s_arburst[1:0];
            end
            S_DATA: begin
                s_rvalid[r_grant] = m_rvalid;
                m_rready          = s_rready[r_grant];
                s_rid             = m_rid;
                s_rdata           = m_rdata;
                s_rresp           = m_rresp;
                s_rlast           = m_rlast;
            end
            default: ;
        endcase
    end
endmodule

// File: doc/axi_read_arbiter_2x1.md
Name:
axi_read_arbiter_2x1

Overview:
Round-robin arbiter that shares one AXI4 slave read port (AR/R) between two AXI4 read masters; one burst in flight at a time. Sits between the testbench/CPU read masters and the memory DUT. Grant is held from AR issue until the R beat with RLAST completes. Widths come from params_pkg.

Parameters:
ID_WIDTH, params_pkg::AXI_ID_WIDTH (4), ARID/RID width
ADDR_WIDTH, params_pkg::AXI_ADDR_WIDTH (32), ARADDR width
DATA_WIDTH, params_pkg::AXI_DATA_WIDTH (32), RDATA width
LEN_WIDTH, params_pkg::AXI_LEN_WIDTH (8), ARLEN width

Ports:
ACLK  in  1  clock; all logic on rising edge
ARESETn  in  1  asynchronous active-low reset
s_arvalid  in  2  per-master AR valid, bit i = master i
s_arready  out  2  per-master AR ready
s_arid  in  2*ID_WIDTH  packed ARID, master i at [i*ID_WIDTH +: ID_WIDTH]
s_araddr  in  2*ADDR_WIDTH  packed ARADDR
s_arlen  in  2*LEN_WIDTH  packed ARLEN
s_arsize  in  6  packed ARSIZE (3 bits each)
s_arburst  in  4  packed ARBURST (2 bits each)
s_rvalid  out  2  per-master R valid
s_rready  in  2  per-master R ready
s_rid  out  ID_WIDTH  RID, broadcast to both
s_rdata  out  DATA_WIDTH  RDATA, broadcast
s_rresp  out  2  RRESP, broadcast
s_rlast  out  1  RLAST, broadcast
m_arvalid  out  1  slave-side AR valid
m_arready  in  1  slave-side AR ready
m_arid  out  ID_WIDTH  granted ARID
m_araddr  out  ADDR_WIDTH  granted ARADDR
m_arlen  out  LEN_WIDTH  granted ARLEN
m_arsize  out  3  granted ARSIZE
m_arburst  out  2  granted ARBURST
m_rvalid  in  1  slave R valid
m_rready  out  1  R ready from granted master
m_rid, m_rdata, m_rresp, m_rlast  in  ID_WIDTH/DATA_WIDTH/2/1  slave R payload
len_err  out  1  sticky: RLAST beat count != ARLEN+1

Behaviour:
- FSM: IDLE, ADDR, DATA. Registers: state, grant (1b), prio (1b, master with priority next), beat_cnt (LEN_WIDTH+1 b), len_q (captured ARLEN), len_err.
- Reset (async assert, sync-safe deassert): state=IDLE, grant=0, prio=0, beat_cnt=0, len_err=0; all outputs 0 (s_arready=0, s_rvalid=0, m_arvalid=0, m_rready=0, payload 0 when not in ADDR/DATA).
- IDLE: no outputs asserted. If s_arvalid!=0: grant<=prio if s_arvalid[prio], else the other; state<=ADDR. One-cycle arbitration latency: m_arvalid first high the cycle after the request is sampled.
- ADDR: m_ar* = combinational mux of granted master; s_arready[grant]=m_arready, other bit 0. On m_arvalid&&m_arready: len_q<=m_arlen, beat_cnt<=0, state<=DATA. Master dropping ARVALID here is a protocol violation; no timeout, stays in ADDR.
- DATA: s_rvalid[grant]=m_rvalid, other 0; m_rready=s_rready[grant]; s_r* payload = m_r* unconditionally. Each m_rvalid&&m_rready: beat_cnt++. On beat with m_rlast: if beat_cnt!=len_q then len_err<=1; prio<=~grant; state<=IDLE. RLAST is authoritative (early/late RLAST still releases grant).
- beat_cnt is LEN_WIDTH+1 bits: ARLEN=255 counts to 255 without wrap before the last beat.
- Non-granted master's ARVALID ignored (s_arready=0) until re-arbitration; turnaround: RLAST handshake cycle N, IDLE N+1, m_arvalid N+2.
- No AR/R overlap, no ID remapping: RID passes through unchanged.
- len_err cleared only by reset.

Test Plan:
- Master0 AR addr 0x1000 len 3, m_arready=1 -> m_araddr=0x1000, m_arvalid 1 cycle after request; 4 beats to master0, s_rvalid[1]=0 throughout; len_err=0.
- Both masters request continuously after reset (addr 0x100 / 0x200, len 0) -> grant order 0,1,0,1; each m_arvalid 2 cycles after prior RLAST.
- m_arready low 5 cycles, s_rready[1] toggling during len 7 burst -> s_arready[1] mirrors m_arready, m_rready mirrors s_rready[1], 8 beats, none lost or duplicated.
- ARLEN=3, slave asserts RLAST on beat 2 -> return to IDLE, len_err=1 and remains 1 across later correct bursts.
- ARESETn low mid-DATA -> all valid/ready outputs 0 same cycle, len_err=0; after release, simultaneous requests grant master0 first.
- ARLEN=255 -> 256 beats, beat_cnt no wrap, len_err=0.
